serial_subtract_sequencer: RTL and testbench
============================================

// Module: serial_subtract_sequencer
// PURPOSE
//   Bit-serial N-bit subtractor controller. Time-shares a single 1-bit full
//   subtractor (full_subtractor_demux, instantiated inside) over WIDTH cycles,
//   LSB first, to compute A - B - Bin. Sits between a valid/ready producer of
//   operand pairs and a valid/ready consumer of results. Trades area for latency.
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range >= 1
// PORTS
//   clk        in   1      single clock; all state updates on posedge
//   rst_n      in   1      synchronous, active-low reset
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      block can accept operands (1 only in IDLE)
//   a          in   WIDTH  minuend, unsigned
//   b          in   WIDTH  subtrahend, unsigned
//   bin        in   1      initial borrow-in
//   out_valid  out  1      result valid (1 only in DONE)
//   out_ready  in   1      consumer accepts result
//   diff       out  WIDTH  (a - b - bin) mod 2^WIDTH
//   bout       out  1      final borrow: 1 iff a < b + bin (unsigned)
//   busy       out  1      1 in RUN or DONE
// BEHAVIOUR
//   Reset: rst_n=0 at posedge -> state IDLE; diff=0, bout=0, out_valid=0,
//     busy=0, in_ready=1 after that edge; shift regs, counter, borrow cleared.
//   Reset mid-operation: aborts with no result; no out_valid pulse.
//   FSM states IDLE, RUN, DONE:
//   - IDLE: in_ready=1. Edge with in_valid=1 -> latch a,b into shift regs,
//     borrow reg <= bin, bit counter <= 0, go RUN. Otherwise stay.
//   - RUN: in_ready=0. Each cycle feeds A_sr[0], B_sr[0], borrow reg to the
//     full subtractor. At edge: D shifted into diff reg from MSB side; borrow
//     reg <= Bout; A_sr, B_sr shift right; counter++. At the edge where
//     counter==WIDTH-1 -> go DONE (exactly WIDTH RUN cycles).
//   - DONE: out_valid=1; diff and bout (= borrow reg) stable until handshake.
//     Edge with out_ready=1 -> IDLE. out_ready=0 -> hold all outputs.
//   Latency: operands accepted at edge T -> out_valid=1 after edge T+WIDTH.
//   Throughput: one op per WIDTH+2 cycles minimum; no IDLE bypass, so
//     in_ready returns 1 the cycle after the result handshake.
//   in_valid / operand changes while not IDLE are ignored.
//   out_ready while not DONE is ignored.
//   diff holds last result in IDLE until overwritten by next RUN;
//     diff is valid only when out_valid=1.
//   Counter width $clog2(WIDTH+1); WIDTH=1 -> single RUN cycle.
//   No arithmetic outside the 1-bit subtractor; all regs unsigned.
// TESTING
//   1. WIDTH=8, a=0x5A, b=0x23, bin=0 -> diff=0x37, bout=0; out_valid 8
//      cycles after accept edge.
//   2. a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1.
//   3. a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0; a=0x00, b=0x00,
//      bin=1 -> diff=0xFF, bout=1.
//   4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1,
//      diff/bout stable, in_ready=0, in_valid pulses ignored; then release
//      -> IDLE next edge.
//   5. Assert rst_n=0 for one edge after 3 RUN cycles -> IDLE, in_ready=1,
//      out_valid never asserted; next op a=0x10, b=0x01 -> diff=0x0F.
//   6. WIDTH=4: exhaustive a, b, bin (512 ops) back-to-back with random
//      out_ready vs reference model -> zero mismatches; in_ready never 1
//      while busy=1.

Source files
------------

// File: rtl/serial_subtract_sequencer.sv
// Bit-serial A - B - Bin sequencer: one 1-bit full subtractor reused over WIDTH
// cycles, LSB first, between valid/ready operand and result interfaces.

module full_subtractor_demux (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic [7:0] line;

  // One-hot decode of the input combination; outputs are ORs of minterms.
  always_comb begin
    line = '0;
    line[{a, b, bin}] = 1'b1;
  end

  assign d    = line[1] | line[2] | line[4] | line[7];
  assign bout = line[1] | line[2] | line[3] | line[7];

endmodule

module serial_subtract_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] a_sr_q,      a_sr_d;
  logic [WIDTH-1:0] b_sr_q,      b_sr_d;
  logic [WIDTH-1:0] diff_q,      diff_d;
  logic             borrow_q,    borrow_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q,      busy_d;

  logic fs_d;
  logic fs_bout;

  full_subtractor_demux u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        diff_d             = diff_q >> 1;
        diff_d[WIDTH-1]    = fs_d;
        borrow_d           = fs_bout;
        a_sr_d             = a_sr_q >> 1;
        b_sr_d             = b_sr_q >> 1;
        cnt_d              = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_RUN) || (state_d == S_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign diff      = diff_q;
  assign bout      = borrow_q;

endmodule

// File: tb/tb_serial_subtract_sequencer.sv
// Self-checking bench: WIDTH=8 directed vectors and corner sequences, plus an
// exhaustive WIDTH=4 run with random backpressure against an arithmetic model.

module tb_serial_subtract_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       in_valid, in_ready, bin, out_valid, out_ready, bout, busy;
  logic [7:0] a, b, diff;

  logic       in_valid4, in_ready4, bin4, out_valid4, out_ready4, bout4, busy4;
  logic [3:0] a4, b4, diff4;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] sb8[$];
  logic [4:0] sb4[$];

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_diff;
    logic       exp_bout;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  serial_subtract_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .busy(busy)
  );

  serial_subtract_sequencer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .bin(bin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .diff(diff4), .bout(bout4), .busy(busy4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair and wait for the result; leaves the DUT in DONE.
  task automatic start_and_wait8(input vec_t v);
    int cyc;
    logic [8:0] exp;
    cyc = 0;
    while (!in_ready && cyc < 20) begin tick(); cyc++; end
    check({v.name, "_in_ready"}, in_ready, 1);
    a = v.a; b = v.b; bin = v.bin; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    sb8.push_back({v.exp_bout, v.exp_diff});
    cyc = 0;
    while (!out_valid && cyc < 40) begin tick(); cyc++; end
    check({v.name, "_latency"}, cyc, 8);
    if (sb8.size() == 0) begin
      check({v.name, "_sb_empty"}, 0, 1);
    end else begin
      exp = sb8.pop_front();
      check({v.name, "_diff"}, diff, exp[7:0]);
      check({v.name, "_bout"}, bout, exp[8]);
    end
  endtask

  task automatic handshake8(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_post_valid"}, out_valid, 0);
    check({name, "_post_ready"}, in_ready, 1);
    check({name, "_post_busy"}, busy, 0);
  endtask

  initial begin
    vec_t v;
    logic [7:0] held_diff;
    int ov_seen;
    int acc_idx, n_done, cyc, viol;
    logic acc, dlv, got_b;
    logic [3:0] got_d;
    logic [4:0] exp5, pend5;

    vecs[0] = '{"sub_5a_23",   8'h5A, 8'h23, 1'b0, 8'h37, 1'b0};
    vecs[1] = '{"sub_00_01",   8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{"sub_80_7f_b", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{"sub_00_00_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{"sub_ff_ff_b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{"sub_ff_00",   8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{"sub_12_34",   8'h12, 8'h34, 1'b0, 8'hDE, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0; out_ready4 = 1'b0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      start_and_wait8(vecs[i]);
      check({vecs[i].name, "_busy_done"}, busy, 1);
      handshake8(vecs[i].name);
    end

    // Backpressure: result held for 5 cycles while new operands are offered.
    v = '{"bp", 8'hC3, 8'h41, 1'b1, 8'h81, 1'b0};
    start_and_wait8(v);
    held_diff = diff;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 8'($urandom);
      b = 8'($urandom);
      out_ready = 1'b0;
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_diff", diff, 8'h81);
      check("bp_diff_stable", diff, held_diff);
      check("bp_bout", bout, 0);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    handshake8("bp");
    tick();
    check("bp_no_stray_accept", busy, 0);

    // Reset three cycles into RUN aborts the operation silently.
    a = 8'h33; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("abort_busy_run", busy, 1);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    ov_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) ov_seen++;
    end
    check("abort_no_result", ov_seen, 0);
    v = '{"post_abort", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
    start_and_wait8(v);
    handshake8("post_abort");
    check("sb8_drained", sb8.size(), 0);

    // Exhaustive WIDTH=4 with random out_ready.
    acc_idx = 0; n_done = 0; cyc = 0; viol = 0;
    while (n_done < 512 && cyc < 20000) begin
      if (in_ready4 && busy4) viol++;
      in_valid4 = (acc_idx < 512);
      {a4, b4, bin4} = 9'(acc_idx);
      out_ready4 = 1'($urandom_range(0, 1));
      acc = in_valid4 && in_ready4;
      dlv = out_valid4 && out_ready4;
      got_d = diff4;
      got_b = bout4;
      pend5 = {1'b0, a4} - {1'b0, b4} - {4'b0, bin4};
      tick();
      cyc++;
      if (acc) begin
        sb4.push_back(pend5);
        acc_idx++;
      end
      if (dlv) begin
        if (sb4.size() == 0) begin
          check("w4_sb_empty", 0, 1);
        end else begin
          exp5 = sb4.pop_front();
          check("w4_diff", got_d, exp5[3:0]);
          check("w4_bout", got_b, exp5[4]);
        end
        n_done++;
      end
    end
    in_valid4 = 1'b0;
    out_ready4 = 1'b0;
    check("w4_ops_done", n_done, 512);
    check("w4_ready_while_busy", viol, 0);
    check("w4_sb_drained", sb4.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
